// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller: Moore FSM producing datapath selects, write enables and the ALU code.
// Define MC_CTRL_LUI_EN to decode opcode 0x0f (lui) through the LUIEX state.
module mc_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iOrD,
    output logic       memWrite,
    output logic       irWrite,
    output logic       pcWrite,
    output logic [1:0] pcSrc,
    output logic [1:0] aluSrcA,
    output logic [2:0] aluSrcB,
    output logic [2:0] aluCtrl,
    output logic       regWrite,
    output logic       regDst,
    output logic       memToReg,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11,
        S_LUIEX  = 4'd12
    } state_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    state_t state_q, state_d;
    logic   pc_we, ir_we, mem_we, reg_we;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // NOTE: every output gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        mem_req  = 1'b0;
        iOrD     = 1'b0;
        mem_we   = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pcSrc    = 2'b00;
        aluSrcA  = 2'b00;
        aluSrcB  = 3'b000;
        aluCtrl  = ALU_ADD;
        reg_we   = 1'b0;
        regDst   = 1'b0;
        memToReg = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                aluSrcB = 3'b001;
                ir_we   = mem_ready;
                pc_we   = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                aluSrcB = 3'b011;
                case (opcode)
                    6'h00: begin
                        case (funct)
                            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25: state_d = S_EXEC;
                            default:                                  state_d = S_FETCH;
                        endcase
                    end
                    6'h23, 6'h2b: state_d = S_MEMADR;
                    6'h04:        state_d = S_BRANCH;
                    6'h0d:        state_d = S_IEXEC;
                    6'h02:        state_d = S_JUMP;
`ifdef MC_CTRL_LUI_EN
                    6'h0f:        state_d = S_LUIEX;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                aluSrcA = 2'b01;
                aluSrcB = 3'b010;
                state_d = (opcode == 6'h2b) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iOrD    = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_we   = 1'b1;
                memToReg = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                iOrD    = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC: begin
                aluSrcA = 2'b01;
                case (funct)
                    6'h22, 6'h23: aluCtrl = ALU_SUB;
                    6'h24:        aluCtrl = ALU_AND;
                    6'h25:        aluCtrl = ALU_OR;
                    default:      aluCtrl = ALU_ADD;
                endcase
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_we  = 1'b1;
                regDst  = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                aluSrcA = 2'b01;
                aluCtrl = ALU_SUB;
                pcSrc   = 2'b01;
                pc_we   = zero;
                state_d = S_FETCH;
            end
            S_IEXEC: begin
                aluSrcA = 2'b01;
                aluSrcB = 3'b100;
                aluCtrl = ALU_OR;
                state_d = S_IWB;
            end
            S_IWB: begin
                reg_we  = 1'b1;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pcSrc   = 2'b10;
                pc_we   = 1'b1;
                state_d = S_FETCH;
            end
`ifdef MC_CTRL_LUI_EN
            S_LUIEX: begin
                aluSrcA = 2'b10;
                aluSrcB = 3'b101;
                state_d = S_IWB;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Write enables are masked by reset so nothing commits while rst_n is low, whatever mem_ready does.
    assign pcWrite  = pc_we  & rst_n;
    assign irWrite  = ir_we  & rst_n;
    assign memWrite = mem_we & rst_n;
    assign regWrite = reg_we & rst_n;
    assign state    = state_q;

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle main controller for the MIPS datapath; it generates the `aluCtrl` code that the ALU consumes, plus every datapath select and write enable. A Moore-style FSM steps each instruction through fetch, decode, execute, memory and writeback. It runs a req/ready handshake with the unified instruction/data memory and sits between the instruction register and the datapath muxes.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `opcode`  in  6  IR[31:26]
- `funct`  in  6  IR[5:0]
- `zero`  in  1  ALU result == 0
- `mem_ready`  in  1  memory completes the current access this cycle
- `mem_req`  out  1  memory access request
- `iOrD`  out  1  address select: 0 = PC, 1 = ALUOut
- `memWrite`  out  1  memory write
- `irWrite`  out  1  load IR
- `pcWrite`  out  1  load PC
- `pcSrc`  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target
- `aluSrcA`  out  2  00 = PC, 01 = regA, 10 = zero
- `aluSrcB`  out  3  000 = regB, 001 = 4, 010 = sign-ext imm, 011 = sign-ext imm<<2, 100 = zero-ext imm, 101 = imm<<16
- `aluCtrl`  out  3  000 = AND, 001 = OR, 010 = ADD, 110 = SUB
- `regWrite`  out  1  register file write
- `regDst`  out  1  0 = rt, 1 = rd
- `memToReg`  out  1  0 = ALUOut, 1 = MDR
- `state`  out  4  current state, for debug

## Operation
- Outputs not listed for a state are 0. `aluCtrl` defaults to 010.
- States and their encodings:
  - FETCH(0): mem_req=1, iOrD=0, A=00, B=001, ADD, pcSrc=00. irWrite = pcWrite = mem_ready. Holds until mem_ready, then goes to DECODE.
  - DECODE(1): A=00, B=011, ADD (precomputes branch target). Next state by opcode:
    - 0x00 goes to EXEC when funct ∈ {0x20,0x21,0x22,0x23,0x24,0x25}; any other funct goes to FETCH.
    - 0x23/0x2b go to MEMADR; 0x04 to BRANCH; 0x0d to IEXEC; 0x02 to JUMP.
    - 0x0f goes to LUIEX (macro only).
    - Any other opcode goes to FETCH and is treated as a nop.
  - MEMADR(2): A=01, B=010, ADD. Goes to MEMRD for lw, MEMWR for sw.
  - MEMRD(3): mem_req=1, iOrD=1. Holds until mem_ready, then goes to MEMWB.
  - MEMWB(4): regWrite=1, regDst=0, memToReg=1. Goes to FETCH.
  - MEMWR(5): mem_req=1, iOrD=1, memWrite=1. Holds until mem_ready, then goes to FETCH.
  - EXEC(6): A=01, B=000. aluCtrl is ADD for funct 0x20/0x21, SUB for 0x22/0x23, AND for 0x24, OR for 0x25. Goes to ALUWB.
  - ALUWB(7): regWrite=1, regDst=1, memToReg=0. Goes to FETCH.
  - BRANCH(8): A=01, B=000, SUB, pcSrc=01, pcWrite=zero. Goes to FETCH.
  - IEXEC(9): A=01, B=100, OR. Goes to IWB.
  - IWB(10): regWrite=1, regDst=0, memToReg=0. Goes to FETCH.
  - JUMP(11): pcSrc=10, pcWrite=1. Goes to FETCH.
  - LUIEX(12): A=10, B=101, ADD. Goes to IWB.
  - Codes 13–15 are illegal and go to FETCH on the next edge, with default outputs.
- Handshake:
  - While mem_req=1, iOrD and memWrite are stable; completion is the edge where mem_ready=1.
  - mem_ready is ignored when mem_req=0.
  - A zero-wait memory (mem_ready tied high) gives single-cycle access states.

## Timing
- Reset: while rst_n=0, state=FETCH and all write enables (pcWrite, irWrite, memWrite, regWrite) are forced to 0, whatever mem_ready is. Other outputs take their FETCH values (aluCtrl=010, mem_req=1).
- First fetch can complete on the first rising edge after rst_n deasserts.
- Cycle counts with zero-wait memory: R-type 4, ori/lui 4, lw 5, sw 4, beq 3, j 3, nop 2. Each wait cycle (mem_ready=0) adds 1 cycle per access.
- State registers and output decode only; there is no output pipelining. Outputs change combinationally from state, plus mem_ready/zero where listed.
- Reset mid-instruction aborts it and returns to FETCH; no partial write completes after the reset edge.

## Configuration
- `MC_CTRL_LUI_EN` defined: opcode 0x0f decodes to LUIEX, then IWB (rt ← imm<<16).
- Undefined: 0x0f is an unknown opcode (DECODE goes to FETCH). State 12 is then illegal and recovers to FETCH.

## Test plan
- Reset with mem_ready=1, then release: pcWrite=irWrite=0 during reset. First edge after release goes FETCH→DECODE with pcWrite=1, aluCtrl=010, aluSrcB=001.
- R-type funct 0x23 (subu): state trace 0,1,6,7,0; EXEC aluCtrl=110; ALUWB regWrite=1, regDst=1.
- lw (0x23) with mem_ready low for 2 cycles in MEMRD: state trace 0,1,2,3,3,3,4,0; iOrD=1 throughout MEMRD; MEMWB memToReg=1.
- beq (0x04): with zero=1, pcWrite=1 and pcSrc=01 in state 8; with zero=0, pcWrite=0. Both return to FETCH.
- Unknown opcode 0x3f, and R-type funct 0x00: both give DECODE→FETCH with no regWrite/memWrite pulse.
- ori (0x0d): state 9 shows aluCtrl=001, aluSrcB=100, then state 10 regWrite=1, regDst=0. Assert rst_n low during MEMWR with mem_ready=0: memWrite drops to 0 immediately and state=0. With `MC_CTRL_LUI_EN`, 0x0f gives trace 0,1,12,10,0.
